// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: 640x480@60 defaults, derived totals and
// the position-to-sync-level decode used on both axes.
package vga_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // Full period of one axis: active, front porch, sync, back porch.
  function automatic int unsigned total(input int unsigned active,
                                        input int unsigned fp,
                                        input int unsigned sync,
                                        input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned DEF_H_TOTAL = total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int unsigned DEF_V_TOTAL = total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  // Sync level for a position: 'pol' inside [first, first+width-1], else its inverse.
  function automatic logic sync_level(input int unsigned pos,
                                      input int unsigned first,
                                      input int unsigned width,
                                      input logic        pol);
    return ((pos >= first) && (pos < first + width)) ? pol : ~pol;
  endfunction

endpackage

// File: rtl/pix_clk_en.sv
// Pixel tick generator: divides CLK by CLK_DIV while enabled.
module pix_clk_en #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned   DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;

  // Tick is left unregistered so the parent can register it with the counters it advances.
  assign tick = en && (div_q == DIV_LAST);

  // Divider advances only while enabled and wraps on the tick cycle.
  always_comb begin
    div_d = div_q;
    if (en) begin
      div_d = tick ? '0 : div_q + DW'(1);
    end
  end

  // Divider register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) div_q <= '0;
    else     div_q <= div_d;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered
// sync, display-enable and line/frame start outputs, all aligned.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = vga_timing_pkg::DEF_H_ACTIVE,
  parameter int unsigned H_FP     = vga_timing_pkg::DEF_H_FP,
  parameter int unsigned H_SYNC   = vga_timing_pkg::DEF_H_SYNC,
  parameter int unsigned H_BP     = vga_timing_pkg::DEF_H_BP,
  parameter int unsigned V_ACTIVE = vga_timing_pkg::DEF_V_ACTIVE,
  parameter int unsigned V_FP     = vga_timing_pkg::DEF_V_FP,
  parameter int unsigned V_SYNC   = vga_timing_pkg::DEF_V_SYNC,
  parameter int unsigned V_BP     = vga_timing_pkg::DEF_V_BP,
  parameter logic        H_POL    = 1'b0,
  parameter logic        V_POL    = 1'b0,
  parameter int unsigned CLK_DIV  = 2,
  localparam int unsigned H_TOTAL = vga_timing_pkg::total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int unsigned V_TOTAL = vga_timing_pkg::total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int unsigned HW      = $clog2(H_TOTAL),
  localparam int unsigned VW      = $clog2(V_TOTAL)
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          EN,
  output logic          PixTick,
  output logic          hSync,
  output logic          vSync,
  output logic          Bright,
  output logic [HW-1:0] Hcnt,
  output logic [VW-1:0] Vcnt,
  output logic          LineStart,
  output logic          FrameStart
);

  import vga_timing_pkg::*;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic          tick;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          pix_tick_q, pix_tick_d;
  logic          h_sync_q, h_sync_d;
  logic          v_sync_q, v_sync_d;
  logic          bright_q, bright_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  pix_clk_en #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_clk_en (
    .clk  (CLK),
    .clr  (CLR),
    .en   (EN),
    .tick (tick)
  );

  // Next position plus decodes of that next position, so every output lands on the same edge.
  always_comb begin
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    pix_tick_d    = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (tick) begin
      pix_tick_d = 1'b1;
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
      end else begin
        hcnt_d = hcnt_q + HW'(1);
      end
      line_start_d  = (hcnt_d == '0);
      frame_start_d = line_start_d && (vcnt_d == '0);
    end
    h_sync_d = sync_level(32'(hcnt_d), H_ACTIVE + H_FP, H_SYNC, H_POL);
    v_sync_d = sync_level(32'(vcnt_d), V_ACTIVE + V_FP, V_SYNC, V_POL);
    bright_d = (32'(hcnt_d) < H_ACTIVE) && (32'(vcnt_d) < V_ACTIVE);
  end

  // Output and counter registers; reset parks on the last back-porch pixel.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      hcnt_q        <= H_LAST;
      vcnt_q        <= V_LAST;
      pix_tick_q    <= 1'b0;
      h_sync_q      <= ~H_POL;
      v_sync_q      <= ~V_POL;
      bright_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      pix_tick_q    <= pix_tick_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      bright_q      <= bright_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign PixTick    = pix_tick_q;
  assign hSync      = h_sync_q;
  assign vSync      = v_sync_q;
  assign Bright     = bright_q;
  assign Hcnt       = hcnt_q;
  assign Vcnt       = vcnt_q;
  assign LineStart  = line_start_q;
  assign FrameStart = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: four configurations checked against a
// linear pixel-index reference model under random EN/CLR stimulus.
module tb_vga_timing_gen;

  typedef struct packed {
    int unsigned ha, hfp, hs, hbp, va, vfp, vs, vbp, div;
    logic        hpol, vpol;
  } cfg_t;

  typedef struct packed {
    logic        tick, hs, vs, br, ls, fs;
    logic [31:0] h, v;
  } obs_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [3:0] clr = '1;
  logic [3:0] en  = '0;
  logic [3:0] pt, hs, vs, br, ls, fs;
  logic [3:0] hc0, hc2, hc3;
  logic [2:0] vc0, vc2, vc3;
  logic [9:0] hc1, vc1;

  obs_t        obs [4];
  cfg_t        cfg [4];
  int unsigned p   [4];
  int unsigned cyc [4];
  logic        tk  [4];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .CLK_DIV(1))
  u_small (.CLK(CLK), .CLR(clr[0]), .EN(en[0]), .PixTick(pt[0]), .hSync(hs[0]), .vSync(vs[0]),
           .Bright(br[0]), .Hcnt(hc0), .Vcnt(vc0), .LineStart(ls[0]), .FrameStart(fs[0]));

  vga_timing_gen #(.CLK_DIV(2))
  u_def (.CLK(CLK), .CLR(clr[1]), .EN(en[1]), .PixTick(pt[1]), .hSync(hs[1]), .vSync(vs[1]),
         .Bright(br[1]), .Hcnt(hc1), .Vcnt(vc1), .LineStart(ls[1]), .FrameStart(fs[1]));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                   .H_POL(1'b1), .V_POL(1'b1), .CLK_DIV(1))
  u_inv (.CLK(CLK), .CLR(clr[2]), .EN(en[2]), .PixTick(pt[2]), .hSync(hs[2]), .vSync(vs[2]),
         .Bright(br[2]), .Hcnt(hc2), .Vcnt(vc2), .LineStart(ls[2]), .FrameStart(fs[2]));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .CLK_DIV(3))
  u_div3 (.CLK(CLK), .CLR(clr[3]), .EN(en[3]), .PixTick(pt[3]), .hSync(hs[3]), .vSync(vs[3]),
          .Bright(br[3]), .Hcnt(hc3), .Vcnt(vc3), .LineStart(ls[3]), .FrameStart(fs[3]));

  assign obs[0] = {pt[0], hs[0], vs[0], br[0], ls[0], fs[0], 32'(hc0), 32'(vc0)};
  assign obs[1] = {pt[1], hs[1], vs[1], br[1], ls[1], fs[1], 32'(hc1), 32'(vc1)};
  assign obs[2] = {pt[2], hs[2], vs[2], br[2], ls[2], fs[2], 32'(hc2), 32'(vc2)};
  assign obs[3] = {pt[3], hs[3], vs[3], br[3], ls[3], fs[3], 32'(hc3), 32'(vc3)};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  function automatic int unsigned htot(input int idx);
    return cfg[idx].ha + cfg[idx].hfp + cfg[idx].hs + cfg[idx].hbp;
  endfunction

  function automatic int unsigned npix(input int idx);
    return htot(idx) * (cfg[idx].va + cfg[idx].vfp + cfg[idx].vs + cfg[idx].vbp);
  endfunction

  // Expected outputs derived from the linear pixel index p (row-major raster position).
  function automatic obs_t model(input int idx);
    cfg_t        c;
    obs_t        e;
    int unsigned hh, vv;
    c    = cfg[idx];
    hh   = p[idx] % htot(idx);
    vv   = p[idx] / htot(idx);
    e.tick = tk[idx];
    e.h    = hh;
    e.v    = vv;
    e.hs   = (hh >= c.ha + c.hfp && hh < c.ha + c.hfp + c.hs) ? c.hpol : ~c.hpol;
    e.vs   = (vv >= c.va + c.vfp && vv < c.va + c.vfp + c.vs) ? c.vpol : ~c.vpol;
    e.br   = (hh < c.ha) && (vv < c.va);
    e.ls   = tk[idx] && (hh == 0);
    e.fs   = tk[idx] && (p[idx] == 0);
    return e;
  endfunction

  // One CLK cycle on DUT idx: drive, advance the model, compare every output.
  task automatic step(input int idx, input logic e_in, input logic c_in);
    obs_t x, o;
    @(negedge CLK);
    en[idx]  = e_in;
    clr[idx] = c_in;
    @(posedge CLK);
    if (c_in) begin
      p[idx]   = npix(idx) - 1;
      cyc[idx] = 0;
      tk[idx]  = 1'b0;
    end else if (e_in) begin
      tk[idx] = ((cyc[idx] % cfg[idx].div) == cfg[idx].div - 1);
      cyc[idx]++;
      if (tk[idx]) p[idx] = (p[idx] + 1) % npix(idx);
    end else begin
      tk[idx] = 1'b0;
    end
    #1;
    x = model(idx);
    o = obs[idx];
    check($sformatf("u%0d.PixTick", idx),    32'(o.tick), 32'(x.tick));
    check($sformatf("u%0d.hSync", idx),      32'(o.hs),   32'(x.hs));
    check($sformatf("u%0d.vSync", idx),      32'(o.vs),   32'(x.vs));
    check($sformatf("u%0d.Bright", idx),     32'(o.br),   32'(x.br));
    check($sformatf("u%0d.LineStart", idx),  32'(o.ls),   32'(x.ls));
    check($sformatf("u%0d.FrameStart", idx), 32'(o.fs),   32'(x.fs));
    check($sformatf("u%0d.Hcnt", idx),       o.h,         x.h);
    check($sformatf("u%0d.Vcnt", idx),       o.v,         x.v);
  endtask

  task automatic reset_dut(input int idx);
    step(idx, 1'b0, 1'b1);
    step(idx, 1'b1, 1'b1);
  endtask

  // Run with EN high until the model sits at (hh, vv); bounded by one frame.
  task automatic run_to(input int idx, input int unsigned hh, input int unsigned vv);
    int unsigned target;
    target = vv * htot(idx) + hh;
    for (int unsigned k = 0; k < npix(idx) * cfg[idx].div + 4 && p[idx] != target; k++)
      step(idx, 1'b1, 1'b0);
    check($sformatf("u%0d.reach", idx), p[idx], target);
  endtask

  // Measure the CLK distance between two consecutive strobes from the DUT.
  task automatic period(input int idx, input logic use_fs, input int unsigned want, input string tag);
    int unsigned first, n;
    first = 0;
    n     = 0;
    for (int unsigned k = 0; k < 2 * want + 4 && n < 2; k++) begin
      step(idx, 1'b1, 1'b0);
      if (use_fs ? obs[idx].fs : obs[idx].ls) begin
        if (n == 0) first = k;
        else        check(tag, k - first, want);
        n++;
      end
    end
    if (n < 2) check({tag, ".seen"}, n, 2);
  endtask

  task automatic random_run(input int idx, input int unsigned cycles);
    for (int unsigned k = 0; k < cycles; k++)
      step(idx, $urandom_range(0, 4) != 0, $urandom_range(0, 299) == 0);
  endtask

  initial begin
    cfg[0] = '{ha: 8, hfp: 2, hs: 3, hbp: 1, va: 4, vfp: 1, vs: 2, vbp: 1, div: 1, hpol: 1'b0, vpol: 1'b0};
    cfg[1] = '{ha: 640, hfp: 16, hs: 96, hbp: 48, va: 480, vfp: 10, vs: 2, vbp: 33, div: 2,
               hpol: 1'b0, vpol: 1'b0};
    cfg[2] = '{ha: 8, hfp: 2, hs: 3, hbp: 1, va: 4, vfp: 1, vs: 2, vbp: 1, div: 1, hpol: 1'b1, vpol: 1'b1};
    cfg[3] = '{ha: 8, hfp: 2, hs: 3, hbp: 1, va: 4, vfp: 1, vs: 2, vbp: 1, div: 3, hpol: 1'b0, vpol: 1'b0};
    for (int i = 0; i < 4; i++) begin
      p[i]   = npix(i) - 1;
      cyc[i] = 0;
      tk[i]  = 1'b0;
    end

    // Small raster, default polarity.
    reset_dut(0);
    check("u0.rst_Hcnt", 32'(hc0), 13);
    check("u0.rst_Vcnt", 32'(vc0), 7);
    step(0, 1'b1, 1'b0);
    check("u0.first_FrameStart", 32'(fs[0]), 1);
    check("u0.first_Bright", 32'(br[0]), 1);
    period(0, 1'b1, 112, "u0.frame_period");
    run_to(0, 3, 1);
    for (int k = 0; k < 5; k++) step(0, 1'b0, 1'b0);
    check("u0.hold_Hcnt", 32'(hc0), 3);
    step(0, 1'b1, 1'b0);
    check("u0.resume_Hcnt", 32'(hc0), 4);
    run_to(0, 9, 2);
    step(0, 1'b1, 1'b1);
    check("u0.clr_Hcnt", 32'(hc0), 13);
    check("u0.clr_Vcnt", 32'(vc0), 7);
    step(0, 1'b1, 1'b0);
    check("u0.clr_FrameStart", 32'(fs[0]), 1);
    run_to(0, 13, 7);
    step(0, 1'b1, 1'b0);
    check("u0.wrap_LineStart", 32'(ls[0]), 1);
    check("u0.wrap_FrameStart", 32'(fs[0]), 1);
    random_run(0, 1500);

    // Default 640x480 timing at CLK_DIV = 2.
    reset_dut(1);
    step(1, 1'b1, 1'b0);
    check("u1.div_first_PixTick", 32'(pt[1]), 0);
    step(1, 1'b1, 1'b0);
    check("u1.div_second_PixTick", 32'(pt[1]), 1);
    check("u1.first_FrameStart", 32'(fs[1]), 1);
    period(1, 1'b0, 1600, "u1.line_period");
    random_run(1, 3000);

    // Small raster, active-high syncs.
    reset_dut(2);
    check("u2.rst_hSync", 32'(hs[2]), 0);
    check("u2.rst_vSync", 32'(vs[2]), 0);
    run_to(2, 10, 5);
    check("u2.sync_hSync", 32'(hs[2]), 1);
    check("u2.sync_vSync", 32'(vs[2]), 1);
    random_run(2, 800);

    // Small raster at CLK_DIV = 3.
    reset_dut(3);
    period(3, 1'b1, 336, "u3.frame_period");
    random_run(3, 1500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
